// File: rtl/sr_ff_arbiter.sv
// sr_ff_arbiter: round-robin sequencer sharing one S/R flag flop between
// N_REQ requesters. Each granted operation is a clean s or r pulse of
// PULSE_CYCLES, followed by GAP_CYCLES quiet cycles, with the ack on the last
// quiet cycle.
// Optional build macro SR_ARB_TOGGLE_EN adds the op_tgl input. A requester
// with op_tgl set flips the flop, using q sampled when its request is latched.
// The file also holds sr_flip_flop, the shared flop this arbiter drives.

module sr_flip_flop (
    input  logic clk,
    input  logic rst,
    input  logic s,
    input  logic r,
    output logic q
);
    // Plain S/R storage; s=r=1 is never driven by the arbiter, treat as hold
    always_ff @(posedge clk) begin
        if (rst)            q <= 1'b0;
        else if (s && !r)   q <= 1'b1;
        else if (r && !s)   q <= 1'b0;
    end
endmodule

module sr_ff_arbiter #(
    parameter int N_REQ        = 4,
    parameter int PULSE_CYCLES = 2,
    parameter int GAP_CYCLES   = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [N_REQ-1:0] req,
    input  logic [N_REQ-1:0] op_set,
`ifdef SR_ARB_TOGGLE_EN
    input  logic [N_REQ-1:0] op_tgl,
`endif
    input  logic             q,
    output logic             s,
    output logic             r,
    output logic [N_REQ-1:0] gnt,
    output logic [N_REQ-1:0] ack,
    output logic             busy
);
    localparam int IDXW = (N_REQ > 1) ? $clog2(N_REQ) : 1;
    localparam int MAXC = (PULSE_CYCLES > GAP_CYCLES) ? PULSE_CYCLES : GAP_CYCLES;
    localparam int CW   = $clog2(MAXC + 1);
    localparam logic [IDXW:0]  N_W    = (IDXW+1)'(N_REQ);
    localparam logic [CW-1:0]  P_LAST = CW'(PULSE_CYCLES - 1);
    localparam logic [CW-1:0]  G_LAST = CW'(GAP_CYCLES - 1);

    typedef enum logic [1:0] {IDLE, DRIVE, GAP} state_t;

    state_t            state, state_nxt;
    logic [IDXW-1:0]   rr_ptr, rr_ptr_nxt;
    logic [IDXW-1:0]   win, win_nxt;
    logic              op, op_nxt;       // 1 = drive s, 0 = drive r
    logic [CW-1:0]     cnt, cnt_nxt;
    logic [N_REQ-1:0]  gnt_nxt;

    logic              found;
    logic [IDXW-1:0]   pick;
    logic [IDXW:0]     scan;
    logic [IDXW:0]     inc;
    logic              pick_op;

`ifdef SR_ARB_TOGGLE_EN
    // Toggle wins over op_set and is resolved against the live flop state
    assign pick_op = op_tgl[pick] ? ~q : op_set[pick];
`else
    logic unused_q;
    assign unused_q = q;
    assign pick_op  = op_set[pick];
`endif

    // Round-robin scan starting at rr_ptr; first asserted request wins
    always_comb begin
        found = 1'b0;
        pick  = '0;
        scan  = '0;
        for (int i = 0; i < N_REQ; i++) begin
            scan = {1'b0, rr_ptr} + (IDXW+1)'(i);
            if (scan >= N_W) scan = scan - N_W;
            if (!found && req[scan[IDXW-1:0]]) begin
                found = 1'b1;
                pick  = scan[IDXW-1:0];
            end
        end
    end

    // Next-state and output decode; s/r/ack come only from registered state
    always_comb begin
        state_nxt  = state;
        cnt_nxt    = cnt;
        win_nxt    = win;
        op_nxt     = op;
        rr_ptr_nxt = rr_ptr;
        inc        = {1'b0, win} + 1'b1;
        s          = 1'b0;
        r          = 1'b0;
        ack        = '0;
        busy       = (state != IDLE);
        case (state)
            IDLE: begin
                if (found) begin
                    state_nxt = DRIVE;
                    cnt_nxt   = '0;
                    win_nxt   = pick;
                    op_nxt    = pick_op;
                end
            end
            DRIVE: begin
                s = op;
                r = ~op;
                if (cnt == P_LAST) begin
                    state_nxt = GAP;
                    cnt_nxt   = '0;
                end else begin
                    cnt_nxt = cnt + 1'b1;
                end
            end
            GAP: begin
                if (cnt == G_LAST) begin
                    ack[win]   = 1'b1;
                    state_nxt  = IDLE;
                    cnt_nxt    = '0;
                    if (inc >= N_W) inc = '0;
                    rr_ptr_nxt = inc[IDXW-1:0];
                end else begin
                    cnt_nxt = cnt + 1'b1;
                end
            end
            default: begin
                state_nxt = IDLE;
                cnt_nxt   = '0;
            end
        endcase
        gnt_nxt = '0;
        if (state_nxt != IDLE) gnt_nxt[win_nxt] = 1'b1;
    end

    // State, latched winner/op, counter, pointer and registered grant
    always_ff @(posedge clk) begin
        if (rst) begin
            state  <= IDLE;
            cnt    <= '0;
            win    <= '0;
            op     <= 1'b0;
            rr_ptr <= '0;
            gnt    <= '0;
        end else begin
            state  <= state_nxt;
            cnt    <= cnt_nxt;
            win    <= win_nxt;
            op     <= op_nxt;
            rr_ptr <= rr_ptr_nxt;
            gnt    <= gnt_nxt;
        end
    end
endmodule
